// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, widths and saturation helper for the FIR filter
package fir_pkg;
  localparam int NTAPS = 10;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int FRAC  = 15;
  localparam int PROD_W = DW + CW;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [CW-1:0] coef_t;

  localparam longint SAT_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam longint SAT_MIN = -(64'sd1 <<< (DW - 1));

  // Callers sign-extend to 64 bits so the helper is independent of tap count.
  function automatic sample_t saturate(input logic signed [63:0] v);
    if (v > SAT_MAX)
      return sample_t'(SAT_MAX[DW-1:0]);
    else if (v < SAT_MIN)
      return sample_t'(SAT_MIN[DW-1:0]);
    else
      return sample_t'(v[DW-1:0]);
  endfunction
endpackage

// File: rtl/fir_mac_tree.sv
// rtl/fir_mac_tree.sv - combinational multiply, accumulate, floor-shift and saturate
module fir_mac_tree
  import fir_pkg::*;
#(
  parameter int NTAPS = fir_pkg::NTAPS
) (
  input  sample_t samples [NTAPS-1:0],
  input  coef_t   taps    [NTAPS-1:0],
  output sample_t y
);
  localparam int AW = DW + CW + $clog2(NTAPS);

  logic signed [DW+CW-1:0] prod [NTAPS-1:0];
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    shifted;

  // Accumulator carries log2(NTAPS) guard bits, so the sum never wraps.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) begin
      prod[k] = samples[k] * taps[k];
      acc     = acc + AW'(prod[k]);
    end
  end

  // Arithmetic shift floors toward minus infinity.
  assign shifted = acc >>> FRAC;
  assign y       = saturate(64'(shifted));
endmodule

// File: rtl/fir_filter.sv
// rtl/fir_filter.sv - 10-tap direct-form FIR, zero-latency output, registered delay line
module fir_filter
  import fir_pkg::*;
#(
  parameter int NTAPS = fir_pkg::NTAPS
) (
  input  logic    clock,
  input  logic    reset,
  input  sample_t xin,
  input  coef_t   taps [NTAPS-1:0],
  output sample_t y
);
  sample_t dly     [NTAPS-2:0];
  sample_t samples [NTAPS-1:0];
  sample_t y_raw;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS - 1; k++) dly[k] <= '0;
    end else begin
      dly[0] <= xin;
      for (int k = 1; k < NTAPS - 1; k++) dly[k] <= dly[k-1];
    end
  end

  // Tap 0 sees the live input; older taps read the delay line.
  always_comb begin
    samples[0] = xin;
    for (int k = 1; k < NTAPS; k++) samples[k] = dly[k-1];
  end

  fir_mac_tree #(
    .NTAPS(NTAPS)
  ) u_mac_tree (
    .samples(samples),
    .taps   (taps),
    .y      (y_raw)
  );

  assign y = reset ? y_raw : '0;
endmodule

// File: tb/tb_fir_filter.sv
// tb/tb_fir_filter.sv - table-driven and golden-model checks of fir_filter
module tb_fir_filter;
  import fir_pkg::*;

  typedef struct {
    bit                  rst_n;
    bit                  max_taps;
    logic signed [15:0]  x;
    logic signed [15:0]  exp;
  } vec_t;

  logic    clock;
  logic    reset;
  sample_t xin;
  coef_t   taps     [NTAPS-1:0];
  coef_t   def_taps [NTAPS-1:0];
  coef_t   max_taps [NTAPS-1:0];
  coef_t   cur_taps [NTAPS-1:0];
  sample_t y;

  int      ntests = 0;
  int      nfail  = 0;
  vec_t    vecs[$];
  longint  hist [NTAPS];

  int dt [NTAPS] = '{3973, 1950, 2264, 2496, 2620, 2620, 2496, 2264, 1950, 3973};
  int step_pos [10] = '{121, 180, 249, 326, 405, 485, 562, 631, 690, 811};
  int imp [10] = '{1986, 975, 1132, 1248, 1310, 1310, 1248, 1132, 975, 1986};

  fir_filter dut (
    .clock(clock),
    .reset(reset),
    .xin  (xin),
    .taps (taps),
    .y    (y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input bit r, input bit m, input int x, input int e);
    vec_t v;
    v.rst_n = r; v.max_taps = m; v.x = 16'(x); v.exp = 16'(e);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input sample_t act, input sample_t exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s[%0d]: y=%0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic sample_t model(input int dummy);
    longint acc = 0;
    for (int k = 0; k < NTAPS; k++) acc += longint'(cur_taps[k]) * hist[k];
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return sample_t'(acc[15:0]) + sample_t'(dummy);
  endfunction

  initial begin
    for (int k = 0; k < NTAPS; k++) begin
      def_taps[k] = 16'(dt[k]);
      max_taps[k] = 16'sh7FFF;
      taps[k]     = def_taps[k];
      hist[k]     = 0;
    end
    reset = 1'b0;
    xin   = '0;

    // Reset state, impulse response
    add(0, 0, 0, 0); add(0, 0, 500, 0);
    add(1, 0, 16384, imp[0]);
    for (int i = 1; i < 10; i++) add(1, 0, 0, imp[i]);
    add(1, 0, 0, 0); add(1, 0, 0, 0);
    // Positive step, immediate tap change, then reset mid-stream
    add(0, 0, 1000, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 1000, step_pos[i]);
    add(1, 0, 1000, 811); add(1, 0, 1000, 811);
    add(1, 1, 1000, 9999); add(1, 0, 1000, 811);
    add(0, 0, 1000, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 1000, step_pos[i]);
    add(1, 0, 1000, 811);
    // Negative step exercises floor rather than truncation
    add(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 0, -1000, -step_pos[i] - 1);
    add(1, 0, -1000, -812);
    // Saturation with all-max taps
    add(0, 1, 0, 0);
    add(1, 1, 32767, 32766);
    for (int i = 0; i < 11; i++) add(1, 1, 32767, 32767);
    add(0, 1, 0, 0);
    add(1, 1, -32768, -32767);
    for (int i = 0; i < 11; i++) add(1, 1, -32768, -32768);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock); #1;
      reset = vecs[i].rst_n;
      xin   = vecs[i].x;
      for (int k = 0; k < NTAPS; k++) taps[k] = vecs[i].max_taps ? max_taps[k] : def_taps[k];
      @(negedge clock);
      check("table", i, y, vecs[i].exp);
    end

    // Golden-model regression: random samples, default then random taps, mid-run reset
    @(posedge clock); #1;
    reset = 1'b0; xin = '0;
    for (int k = 0; k < NTAPS; k++) begin
      cur_taps[k] = def_taps[k]; taps[k] = def_taps[k]; hist[k] = 0;
    end
    @(negedge clock);
    check("regr_reset", 0, y, 16'sd0);
    for (int c = 0; c < 300; c++) begin
      @(posedge clock); #1;
      if (c == 150 || c == 230) begin
        for (int k = 0; k < NTAPS; k++)
          cur_taps[k] = coef_t'($urandom_range(0, 16383)) - 16'sd8192;
      end
      reset = (c == 200) ? 1'b0 : 1'b1;
      xin   = sample_t'($urandom);
      for (int k = 0; k < NTAPS; k++) taps[k] = cur_taps[k];
      if (!reset) begin
        for (int k = 0; k < NTAPS; k++) hist[k] = 0;
      end else begin
        for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'(xin);
      end
      @(negedge clock);
      check("regr", c, y, reset ? model(0) : 16'sd0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
